// File: rtl/test_status_mailbox.sv
// Status mailbox: typed status words queued through a FIFO, with a sticky end-of-test flag and verdict.
// Optional idle watchdog is compiled in with `define TEST_STATUS_MAILBOX_WATCHDOG_EN.
//
// state    | meaning
// RUNNING  | accepting status writes from the design
// DRAINING | END seen (or watchdog fired); writes blocked, waiting for the bench to empty the FIFO
// DONE     | FIFO drained; end_of_test_o held until reset
module test_status_mailbox #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [1:0]                 wr_type_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [1:0]                 rd_type_o,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [7:0]                 error_count_o,
    output logic                       end_of_test_o,
    output logic                       test_passed_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [1:0] T_PASS = 2'b01;
    localparam logic [1:0] T_FAIL = 2'b10;
    localparam logic [1:0] T_END  = 2'b11;

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        DRAINING = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH+1:0]       mem [DEPTH];
    logic [7:0]                  err_q;
    logic                        pass_seen_q;
    logic                        full, empty, push, pop;
    logic                        err_inc;
    logic                        wd_timeout;
    logic [DATA_WIDTH+1:0]       head;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (level_o == PW'(DEPTH));
    assign push    = wr_valid_i && wr_ready_o;
    assign pop     = rd_valid_o && rd_ready_i;

`ifdef TEST_STATUS_MAILBOX_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_cnt_q;

    assign wd_timeout = (state_q == RUNNING) && !push && (wd_cnt_q == WD_LAST);

    // Counts idle cycles; frozen once the FSM has left RUNNING.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_q <= '0;
        end else if (state_q == RUNNING) begin
            if (push) wd_cnt_q <= '0;
            else if (!wd_timeout) wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign wd_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ready_o = 1'b0;
        case (state_q)
            RUNNING: begin
                wr_ready_o = !full;
                if ((push && wr_type_i == T_END) || wd_timeout) state_d = DRAINING;
            end
            DRAINING: begin
                if (empty) state_d = DONE;
            end
            DONE: state_d = DONE;
            default: state_d = RUNNING;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= RUNNING;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Payload storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= {wr_type_i, wr_data_i};
    end

    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign rd_valid_o = !empty;
    assign rd_type_o  = empty ? 2'b00 : head[DATA_WIDTH+1:DATA_WIDTH];
    assign rd_data_o  = empty ? '0 : head[DATA_WIDTH-1:0];

    assign err_inc = (push && wr_type_i == T_FAIL) || wd_timeout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q       <= 8'd0;
            pass_seen_q <= 1'b0;
        end else begin
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (push && wr_type_i == T_PASS) pass_seen_q <= 1'b1;
        end
    end

    assign error_count_o = err_q;
    assign end_of_test_o = (state_q == DONE);
    assign test_passed_o = end_of_test_o && pass_seen_q && (err_q == 8'd0);

endmodule

// File: doc/test_status_mailbox.md
# test_status_mailbox

Synthesizable status mailbox. The design under test posts typed status words (info/pass/fail/end) through a valid/ready write port, and the block buffers them in a FIFO. The bench side drains that FIFO through a valid/ready read port. After the end marker has drained, the block asserts a sticky end-of-test flag that the test package waits on, together with a pass/fail verdict. It is the design-side counterpart of the bench's run/end-of-test control and sits between DUT top and the verification harness.

## Interface
- DATA_WIDTH, 32, status payload width
- DEPTH, 8, FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1000, watchdog limit in cycles (used only when watchdog compiled in)
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset; one clock; asynchronous, active-low
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when valid&ready
- wr_type_i  in  2  00 INFO, 01 PASS, 10 FAIL, 11 END
- wr_data_i  in  DATA_WIDTH  payload
- rd_valid_o  out  1  FIFO head valid
- rd_ready_i  in  1  bench pops head when valid&ready
- rd_type_o  out  2  head type
- rd_data_o  out  DATA_WIDTH  head payload
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- error_count_o  out  8  accepted FAIL writes plus watchdog events, saturating at 255
- end_of_test_o  out  1  sticky, set in DONE
- test_passed_o  out  1  valid only with end_of_test_o

## Operation
- FSM states: RUNNING (reset), DRAINING, DONE.
- RUNNING:
  - wr_ready_o = !full.
  - An accepted write pushes {type,data}.
  - An accepted FAIL increments error_count_o.
  - An accepted PASS sets internal pass_seen.
  - An accepted END is pushed, then the FSM goes to DRAINING.
- DRAINING: wr_ready_o=0. When the FIFO becomes empty (level 0 after a pop), go to DONE.
- DONE:
  - wr_ready_o=0 and writes are ignored.
  - end_of_test_o=1.
  - test_passed_o = pass_seen && error_count_o==0.
  - Leave DONE only through reset.
- FIFO:
  - Register array with DEPTH entries and read/write pointers of $clog2(DEPTH)+1 bits; the MSB gives full/empty disambiguation and the pointers wrap.
  - Head is combinationally presented: rd_valid_o = !empty, rd_data_o/rd_type_o = mem[rd_ptr].
- Simultaneous push and pop:
  - When not full, both occur and level_o is unchanged.
  - When full, the push is not offered (ready=0), so only the pop occurs.
  - When empty, there is no bypass; the write appears next cycle.
- error_count_o saturates at 255 and never wraps.
- Reset (any time, including mid-drain) clears FIFO, pointers, counters, pass_seen, and FSM state. All outputs go to 0 except wr_ready_o=1.

## Timing
- Write accepted at edge N: rd_valid_o=1 and level_o incremented after edge N. Write-to-read latency is 1 cycle.
- Pop at edge N: the next entry is presented after edge N.
- END is the last entry popped. end_of_test_o rises 1 cycle after the edge that pops END.
- wr_ready_o and rd_valid_o are derived combinationally from registered state. The block has no combinational path from input valid to output ready.

## Configuration
- Macro TEST_STATUS_MAILBOX_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in RUNNING and clears on every accepted write.
  - On reaching TIMEOUT_CYCLES, error_count_o increments and the FSM goes to DRAINING, with no FIFO entry.
  - The counter is frozen outside RUNNING.
- Undefined: no counter and no timeout. TIMEOUT_CYCLES is ignored, and the block can remain in RUNNING indefinitely.

## Test plan
- Reset, then write INFO 0x11, PASS 0x22, END 0x0, read with rd_ready_i=1 → bench reads types 00, 01, 11 in order; end_of_test_o=1 one cycle after the END pop; test_passed_o=1; error_count_o=0.
- With rd_ready_i=0, write 8 INFO words → level_o=8 and wr_ready_o=0. Pop once with no new write → level_o=7 and wr_ready_o=1. Then push and pop in the same cycle → level_o stays 7.
- PASS, FAIL 0xBAD, END → error_count_o=1; test_passed_o=0 at DONE.
- 300 FAIL writes interleaved with pops, then END → error_count_o=255 (saturated).
- Assert rst_n_i low in DRAINING with 3 entries queued → immediately level_o=0, rd_valid_o=0, end_of_test_o=0, wr_ready_o=1.
- Watchdog build with TIMEOUT_CYCLES=20: one INFO write then idle → error_count_o=1 after 20 idle cycles. After the INFO is popped → end_of_test_o=1 and test_passed_o=0. Non-watchdog build, same stimulus → still RUNNING after 1000 cycles.
